d_mem_responder: RTL and testbench
==================================

// Module: d_mem_responder
// PURPOSE
//   Memory-side responder for the data-cache memory bus (m_a/m_din/m_dout/m_strobe/
//   m_wen/m_size/m_rw/m_ready). Completes word refills, dirty write-backs and uncached
//   accesses from d_cache with a programmable wait-state count.
//   Backed by an internal word-addressed RAM. Serves as the data-memory model in
//   simulation and as the on-chip data RAM slave.
// PARAMETERS
//   A_WIDTH  32  address width
//   M_INDEX  10  log2 of RAM depth in 32-bit words
//   LATENCY   2  cycles from request acceptance to m_ready; legal range 1..15
// PORTS
//   clk       in   1        single clock, all logic on posedge
//   rst       in   1        synchronous, active-high reset
//   m_a       in   A_WIDTH  byte address; word index = m_a[M_INDEX+1:2]
//   m_din     in   32       write data from master
//   m_dout    out  32       read data to master
//   m_strobe  in   1        request valid; master holds it high until m_ready
//   m_wen     in   4        byte enables; m_wen[3]->[31:24] ... m_wen[0]->[7:0]
//   m_size    in   2        0=byte 1=half 2=word; informational, not decoded
//   m_rw      in   1        0=read 1=write
//   m_ready   out  1        one-cycle completion pulse
//   busy      out  1        high while a request is in flight
// BEHAVIOUR
// - Reset: one clock, synchronous active-high (clk/rst).
//   - State goes to IDLE. m_ready=0, busy=0, m_dout=0, wait counter=0.
//   - RAM contents are not cleared.
// - FSM states:
//   - IDLE: if m_strobe=1, latch m_a/m_din/m_wen/m_rw. Load counter with LATENCY-1.
//     Go to WAIT, or to RESP if LATENCY=1.
//   - WAIT: decrement counter each cycle; at 0, go to RESP.
//     If m_strobe=0 here (abort), go to IDLE with no RAM write and no m_ready.
//   - RESP: assert m_ready for exactly this one cycle, then go to IDLE.
//     The abort rule does not apply in RESP.
// - Request timing:
//   - A request accepted in cycle N gets m_ready in cycle N+LATENCY.
//   - Master inputs that change after acceptance are ignored, except the m_strobe abort.
// - Access commit, in the cycle the FSM enters RESP (on the transition edge):
//   - Read: m_dout <= RAM[idx]. Value is valid during the m_ready cycle and held until
//     the next read completes.
//   - Write: RAM[idx] byte lanes updated where latched m_wen=1. m_wen=0000 completes
//     with no change. m_dout is unchanged.
// - Back-to-back requests:
//   - IDLE re-samples m_strobe in the cycle after RESP.
//   - So if m_strobe stays high across m_ready (write-back followed by refill), that is
//     a new request at cycle R+1. Minimum spacing between m_ready pulses is LATENCY+1.
//   - Only one request is ever outstanding.
// - Address handling:
//   - m_a[1:0] is ignored; lanes come from m_wen only.
//   - Bits above M_INDEX+1 are ignored, so addresses alias modulo depth.
//   - Read-after-write to the same word returns the new data.
// - busy = (state != IDLE).
// - Reset asserted mid-operation: FSM goes to IDLE, pending request is dropped, no RAM
//   write, m_ready=0 in the next cycle.
// TESTING
// - Single read, LATENCY=2:
//   - Preload RAM[5]=32'hDEADBEEF; strobe rd at addr 0x14 in cycle 0.
//   - Expect m_ready=1 only in cycle 2 with m_dout=DEADBEEF; busy high in cycles 1-2.
// - Byte write:
//   - RAM[3]=32'h11223344; write addr 0x0C, m_wen=0100, din=32'hAABBCCDD.
//   - Read back returns 32'h11BB3344.
// - Write-back then refill with m_strobe held high:
//   - wr addr 0x40 then rd addr 0x80 in the cycle after m_ready.
//   - Expect two m_ready pulses 3 cycles apart (LATENCY=2). The read returns its own
//     word, and RAM[16] holds the written data.
// - Abort:
//   - Write accepted, then m_strobe dropped in WAIT.
//   - Expect no m_ready, RAM unchanged, busy=0 the next cycle.
// - Reset mid-WAIT, and LATENCY=1:
//   - rst in WAIT: m_ready never pulses and no write occurs.
//   - LATENCY=1: a read accepted in cycle 0 gives m_ready in cycle 1.
//   - Address aliasing: addr (1<<(M_INDEX+2))+8 hits RAM[2].

Source files
------------

// File: rtl/d_mem_responder.sv
// Memory-side responder for the data-cache bus: a single outstanding request completes
// after LATENCY cycles against an internal word-addressed RAM split into byte lanes.
module d_mem_responder #(
   parameter int A_WIDTH = 32,
   parameter int M_INDEX = 10,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [A_WIDTH-1:0] m_a,
   input  logic [31:0]        m_din,
   output logic [31:0]        m_dout,
   input  logic               m_strobe,
   input  logic [3:0]         m_wen,
   input  logic [1:0]         m_size,
   input  logic               m_rw,
   output logic               m_ready,
   output logic               busy
);

   localparam int DEPTH = 1 << M_INDEX;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [M_INDEX-1:0] idx_q, idx_d;
   logic [31:0]        din_q, din_d;
   logic [3:0]         wen_q, wen_d;
   logic               rw_q, rw_d;

   // Access performed on the edge that enters RESP; with LATENCY=1 it uses live inputs.
   logic               commit;
   logic               commit_rw;
   logic [M_INDEX-1:0] commit_idx;
   logic [31:0]        commit_din;
   logic [3:0]         commit_wen;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      din_d      = din_q;
      wen_d      = wen_q;
      rw_d       = rw_q;
      commit     = 1'b0;
      commit_rw  = rw_q;
      commit_idx = idx_q;
      commit_din = din_q;
      commit_wen = wen_q;
      case (state_q)
         ST_IDLE: begin
            if (m_strobe) begin
               idx_d = m_a[M_INDEX+1:2];
               din_d = m_din;
               wen_d = m_wen;
               rw_d  = m_rw;
               cnt_d = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d    = ST_RESP;
                  commit     = 1'b1;
                  commit_rw  = m_rw;
                  commit_idx = m_a[M_INDEX+1:2];
                  commit_din = m_din;
                  commit_wen = m_wen;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Abort takes priority even in the last wait cycle, so nothing commits.
            if (!m_strobe) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         din_q   <= '0;
         wen_q   <= '0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         din_q   <= din_d;
         wen_q   <= wen_d;
         rw_q    <= rw_d;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (!rst && commit && commit_rw && commit_wen[gi])
            mem[commit_idx] <= commit_din[gi*8 +: 8];
      end

      always_ff @(posedge clk) begin
         if (rst)
            rd_q <= '0;
         else if (commit && !commit_rw)
            rd_q <= mem[commit_idx];
      end

      assign m_dout[gi*8 +: 8] = rd_q;
   end

   assign m_ready = (state_q == ST_RESP);
   assign busy    = (state_q != ST_IDLE);

   logic unused_bits;
   assign unused_bits = ^{m_size, m_a[1:0], m_a[A_WIDTH-1:M_INDEX+2]};

endmodule

// File: tb/tb_d_mem_responder.sv
// Randomized bench for d_mem_responder: a cycle-timed behavioural model checks the
// LATENCY=2 instance every cycle; a LATENCY=1 instance gets short directed checks.
module tb_d_mem_responder;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] m_a, m_din;
   logic [3:0]  m_wen;
   logic [1:0]  m_size;
   logic        m_rw, m_strobe;
   logic [31:0] m_dout;
   logic        m_ready, busy;

   logic [31:0] s1_a, s1_din;
   logic [3:0]  s1_wen;
   logic [1:0]  s1_size;
   logic        s1_rw, s1_strobe;
   logic [31:0] s1_dout;
   logic        s1_ready, s1_busy;

   d_mem_responder #(.A_WIDTH(32), .M_INDEX(10), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
      .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
      .m_ready(m_ready), .busy(busy));

   d_mem_responder #(.A_WIDTH(32), .M_INDEX(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .m_a(s1_a), .m_din(s1_din), .m_dout(s1_dout),
      .m_strobe(s1_strobe), .m_wen(s1_wen), .m_size(s1_size), .m_rw(s1_rw),
      .m_ready(s1_ready), .busy(s1_busy));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always_ff @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: a request accepted in cycle acc is busy for acc+1..acc+LAT,
   // ready in acc+LAT, commits at the end of acc+LAT-1 unless strobe fell in a wait cycle.
   logic [31:0] mdl_mem [0:1023];
   bit          pend = 1'b0;
   int          acc  = 0;
   bit          p_rw;
   int          p_idx;
   logic [3:0]  p_wen;
   logic [31:0] p_din;
   logic [31:0] mdl_dout = '0;

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("busy", {31'd0, busy}, {31'd0, pend});
         chk("ready", {31'd0, m_ready}, {31'd0, pend && (cyc == acc + LAT)});
         chk("dout", m_dout, mdl_dout);
      end
      if (rst) begin
         pend     = 1'b0;
         mdl_dout = '0;
      end else begin
         if (pend && cyc == acc + LAT) pend = 1'b0;
         else if (pend && cyc > acc && !m_strobe) pend = 1'b0;
         else if (!pend && m_strobe) begin
            pend  = 1'b1;
            acc   = cyc;
            p_rw  = m_rw;
            p_idx = int'(m_a[11:2]);
            p_wen = m_wen;
            p_din = m_din;
         end
         if (pend && cyc == acc + LAT - 1) begin
            if (p_rw) begin
               for (int b = 0; b < 4; b++)
                  if (p_wen[b]) mdl_mem[p_idx][8*b +: 8] = p_din[8*b +: 8];
            end else begin
               mdl_dout = mdl_mem[p_idx];
            end
         end
      end
   end

   // Called at #1 after a posedge; returns at #1 after the posedge following m_ready.
   task automatic req(input bit rw, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] w, input bit hold, input bit scramble,
                      output int acc_c, output int rdy_c);
      m_rw = rw; m_a = a; m_din = d; m_wen = w; m_size = 2'($urandom);
      m_strobe = 1'b1;
      acc_c = cyc;
      rdy_c = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (m_ready) begin
            rdy_c = cyc;
            break;
         end
         @(posedge clk); #1;
         if (scramble) begin
            m_a = $urandom; m_din = $urandom; m_wen = 4'($urandom); m_rw = 1'($urandom);
         end
      end
      chk("req_completed", {31'd0, rdy_c >= 0}, 32'd1);
      @(posedge clk); #1;
      if (!hold) m_strobe = 1'b0;
   endtask

   task automatic abort_req(input bit rw, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] w, input bit lit);
      m_rw = rw; m_a = a; m_din = d; m_wen = w; m_strobe = 1'b1;
      @(posedge clk); #1;
      m_strobe = 1'b0;
      @(negedge clk);
      if (lit) begin
         chk("abort_busy_wait", {31'd0, busy}, 32'd1);
         chk("abort_ready_wait", {31'd0, m_ready}, 32'd0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      if (lit) begin
         chk("abort_busy_after", {31'd0, busy}, 32'd0);
         chk("abort_ready_after", {31'd0, m_ready}, 32'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic reset_req(input logic [31:0] a, input logic [31:0] d, input bit lit);
      m_rw = 1'b1; m_a = a; m_din = d; m_wen = 4'hF; m_strobe = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; m_strobe = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      if (lit) begin
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_ready", {31'd0, m_ready}, 32'd0);
      end
      @(posedge clk); #1;
   endtask

   int ac, rc, ac2, rc2;
   logic [31:0] addr;

   initial begin
      rst = 1'b1;
      m_a = '0; m_din = '0; m_wen = '0; m_size = '0; m_rw = 1'b0; m_strobe = 1'b0;
      s1_a = '0; s1_din = '0; s1_wen = '0; s1_size = '0; s1_rw = 1'b0; s1_strobe = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_ready", {31'd0, m_ready}, 32'd0);
      chk("reset_dout", m_dout, 32'd0);
      chk("reset1_dout", s1_dout, 32'd0);
      @(posedge clk); #1;

      // LATENCY=1 instance: write word 4, then read it back with strobe held across m_ready.
      s1_rw = 1'b1; s1_a = 32'h10; s1_din = 32'h4444_0001; s1_wen = 4'hF; s1_strobe = 1'b1;
      @(negedge clk); chk("l1_wr_ready0", {31'd0, s1_ready}, 32'd0);
      @(posedge clk); #1; s1_strobe = 1'b0;
      @(negedge clk); chk("l1_wr_ready1", {31'd0, s1_ready}, 32'd1);
      chk("l1_wr_busy1", {31'd0, s1_busy}, 32'd1);
      @(posedge clk); #1;
      s1_rw = 1'b0; s1_a = 32'h10; s1_strobe = 1'b1;
      @(negedge clk); chk("l1_rd_ready0", {31'd0, s1_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("l1_rd_ready1", {31'd0, s1_ready}, 32'd1);
      chk("l1_rd_data", s1_dout, 32'h4444_0001);
      @(posedge clk); #1;
      @(negedge clk); chk("l1_b2b_gap", {31'd0, s1_ready}, 32'd0);
      chk("l1_b2b_gap_busy", {31'd0, s1_busy}, 32'd0);
      @(posedge clk); #1; s1_strobe = 1'b0;
      @(negedge clk); chk("l1_b2b_ready", {31'd0, s1_ready}, 32'd1);
      @(posedge clk); #1;

      // Preload every word the random phase may read.
      for (int i = 0; i < 40; i++) req(1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0, 1'b0, ac, rc);

      // Single read with LATENCY=2.
      req(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, ac, rc);
      req(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 1'b0, ac, rc);
      chk("rd_latency", 32'(rc - ac), 32'd2);
      chk("rd_data", m_dout, 32'hDEAD_BEEF);

      // Byte-lane write.
      req(1'b1, 32'h0C, 32'h1122_3344, 4'hF, 1'b0, 1'b0, ac, rc);
      req(1'b1, 32'h0C, 32'hAABB_CCDD, 4'b0100, 1'b0, 1'b0, ac, rc);
      req(1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, 1'b0, ac, rc);
      chk("byte_write", m_dout, 32'h11BB_3344);

      // Write-back then refill, strobe held across m_ready.
      req(1'b1, 32'h80, 32'h3232_3232, 4'hF, 1'b0, 1'b0, ac, rc);
      req(1'b1, 32'h40, 32'h5A5A_1234, 4'hF, 1'b1, 1'b0, ac, rc);
      req(1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 1'b0, ac2, rc2);
      chk("b2b_spacing", 32'(rc2 - rc), 32'd3);
      chk("b2b_refill", m_dout, 32'h3232_3232);
      req(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, ac, rc);
      chk("b2b_writeback", m_dout, 32'h5A5A_1234);

      // Abort and reset mid-wait leave RAM untouched.
      req(1'b1, 32'h24, 32'h1234_5678, 4'hF, 1'b0, 1'b0, ac, rc);
      abort_req(1'b1, 32'h24, 32'hFFFF_FFFF, 4'hF, 1'b1);
      req(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 1'b0, ac, rc);
      chk("abort_ram", m_dout, 32'h1234_5678);
      req(1'b1, 32'h1C, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, ac, rc);
      reset_req(32'h1C, 32'hEEEE_EEEE, 1'b1);
      req(1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 1'b0, ac, rc);
      chk("rst_ram", m_dout, 32'h0BAD_F00D);

      // Aliasing and ignored low address bits.
      req(1'b1, (32'd1 << 12) + 32'd8, 32'hC0DE_0002, 4'hF, 1'b0, 1'b0, ac, rc);
      req(1'b0, 32'h0B, 32'h0, 4'h0, 1'b0, 1'b0, ac, rc);
      chk("alias", m_dout, 32'hC0DE_0002);

      // Randomized traffic, checked every cycle by the model.
      for (int t = 0; t < 200; t++) begin
         int r;
         bit hold;
         r    = $urandom_range(0, 19);
         addr = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 39)) << 2);
         hold = 1'b0;
         if (r == 0) reset_req(addr, $urandom, 1'b0);
         else if (r <= 2) abort_req(1'($urandom), addr, $urandom, 4'($urandom), 1'b0);
         else begin
            hold = (r % 4 == 3);
            req(1'($urandom), addr, $urandom, (r == 4) ? 4'h0 : 4'($urandom),
                hold, 1'($urandom), ac, rc);
         end
         if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      m_strobe = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
